// File: rtl/logic_table_pkg.sv
// Shared types and sizing constants for the logic-table forward/inverse blocks.
package logic_table_pkg;

  localparam int TABLE_ENTRIES = 16;
  localparam int IN_W          = 4;
  localparam int CODE_W        = 5;
  localparam int MAX_MATCHES   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_table_lookup.sv
// Forward truth table: input combination {A,B,C,D} -> output code {V,W,X,Y,Z}.
module logic_table_lookup
  import logic_table_pkg::*;
(
  input  logic [IN_W-1:0]   index_i,
  output logic [CODE_W-1:0] code_o
);

  always_comb begin
    code_o = '0;
    case (index_i)
      4'd0:  code_o = 5'd20;
      4'd1:  code_o = 5'd19;
      4'd2:  code_o = 5'd19;
      4'd3:  code_o = 5'd18;
      4'd4:  code_o = 5'd18;
      4'd5:  code_o = 5'd17;
      4'd6:  code_o = 5'd17;
      4'd7:  code_o = 5'd16;
      4'd8:  code_o = 5'd16;
      4'd9:  code_o = 5'd15;
      4'd10: code_o = 5'd15;
      4'd11: code_o = 5'd14;
      4'd12: code_o = 5'd14;
      4'd13: code_o = 5'd13;
      4'd14: code_o = 5'd13;
      4'd15: code_o = 5'd12;
    endcase
  end

endmodule

// File: rtl/logic_table_inverse.sv
// Inverse of the forward table: scans all inputs once per request and reports
// how many inputs map to the requested code, plus the lowest and highest match.
module logic_table_inverse
  import logic_table_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_count,
  output logic [IN_W-1:0]   rsp_first,
  output logic [IN_W-1:0]   rsp_last,
  output logic              busy
);

  state_e            state_q;
  logic [CODE_W-1:0] code_q;
  logic [IN_W-1:0]   idx_q;
  logic [1:0]        count_q, count_d;
  logic [IN_W-1:0]   first_q, first_d;
  logic [IN_W-1:0]   last_q, last_d;
  logic              req_ready_q, rsp_valid_q, busy_q;

  logic [CODE_W-1:0] fwd_code;
  logic              hit, below, last_idx;

  logic_table_lookup u_lookup (
    .index_i (idx_q),
    .code_o  (fwd_code)
  );

  assign hit      = (fwd_code == code_q);
  assign below    = (fwd_code < code_q);
  assign last_idx = (idx_q == IN_W'(TABLE_ENTRIES - 1));

  // First match seeds both ends; later matches only move the upper end.
  always_comb begin
    count_d = count_q;
    first_d = first_q;
    last_d  = last_q;
    if (hit) begin
      if (count_q == 2'd0) begin
        first_d = idx_q;
      end
      last_d = idx_q;
      if (count_q != 2'(MAX_MATCHES)) begin
        count_d = count_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      first_q     <= '0;
      last_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            code_q      <= req_code;
            idx_q       <= '0;
            count_q     <= '0;
            first_q     <= '0;
            last_q      <= '0;
            state_q     <= SCAN;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SCAN: begin
          count_q <= count_d;
          first_q <= first_d;
          last_q  <= last_d;
          idx_q   <= idx_q + 1'b1;
          // Table is non-increasing, so once it drops below the target no later entry can match.
          if (last_idx || (EARLY_EXIT && below)) begin
            state_q     <= RESP;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign rsp_count = count_q;
  assign rsp_first = first_q;
  assign rsp_last  = last_q;

endmodule

// File: doc/logic_table_inverse.md
Name: logic_table_inverse

Overview:
Sequential inverse of the team's 4-input/5-output truth-table function. It accepts a 5-bit output code {V,W,X,Y,Z} and scans all 16 input combinations {A,B,C,D} through the forward table. It reports how many combinations produce that code and which ones, giving lowest and highest match. It sits behind a valid/ready request port and returns one response per request on a valid/ready response port.

Parameters:
EARLY_EXIT, 0, 1 = stop scanning once the forward value drops below the target code (forward table is monotonic non-increasing); 0 = always scan all 16 entries

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_code  input  5  target code {V,W,X,Y,Z}, MSB = V
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_count  output  2  number of matching inputs: 0, 1 or 2
rsp_first  output  4  lowest matching {A,B,C,D}; 0 if count = 0
rsp_last  output  4  highest matching {A,B,C,D}; equals rsp_first if count = 1; 0 if count = 0
busy  output  1  high in SCAN

Behaviour:
- Forward function f(n), n = {A,B,C,D} in 0..15: f(n) = 20 - floor((n+1)/2). The range is 20 (n = 0) down to 12 (n = 15). Codes 13..19 map to n = 2k-1, 2k. Codes 0..11 and 21..31 have no preimage.
- Reset (rst_n low, async): state IDLE, req_ready = 1, rsp_valid = 0, busy = 0, rsp_count = 0, rsp_first = 0, rsp_last = 0, index = 0, latched code = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch req_code, clear index/count/first/last, go to SCAN.
- SCAN:
  - req_ready = 0, busy = 1.
  - Each cycle evaluates f(index) against the latched code.
  - On match: if count = 0, set first = last = index; otherwise set last = index. Count saturates at 2.
  - Index increments by 1 per cycle.
  - Exit to RESP after evaluating index 15. This is exactly 16 SCAN cycles, with no wrap-around.
  - EARLY_EXIT = 1: also exit to RESP in the cycle where f(index) < code. The current index is evaluated (no match possible) and the scan ends.
- RESP:
  - rsp_valid = 1 and outputs held stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready = 0 while in RESP; no request is buffered.
- Latency (EARLY_EXIT = 0):
  - Request accepted at edge T.
  - rsp_valid rises after edge T+16.
  - With rsp_ready tied high, req_ready returns 1 after edge T+17.
- Back-to-back: a new request can be accepted in the first IDLE cycle after the response handshake. There is no same-cycle overlap.
- rsp_ready held low: the block stalls in RESP indefinitely, with outputs stable.
- req_valid while busy: ignored (req_ready = 0); the requester must hold it.
- Reset asserted mid-SCAN or in RESP: immediate return to reset values. The in-flight request is lost and no response is issued.
- All arithmetic is unsigned. f() is computed in 5 bits; index is 4 bits plus a terminal flag, or 5 bits.

Decomposition:
- Package logic_table_pkg:
  - state enum {IDLE, SCAN, RESP}
  - constants TABLE_ENTRIES = 16, IN_W = 4, CODE_W = 5, MAX_MATCHES = 2
- Sub-module logic_table_lookup: purely combinational forward function, index[3:0] -> code[4:0], case-based 16-entry table. It is instanced once inside the scanner and reused by the bench as a reference model.

Test Plan:
- Reset, then req_code = 20 -> rsp_count = 1, rsp_first = 0, rsp_last = 0; rsp_valid exactly 16 cycles after acceptance.
- req_code = 17 -> rsp_count = 2, rsp_first = 5, rsp_last = 6. req_code = 12 -> count = 1, first = last = 15.
- req_code = 5 and req_code = 25 -> rsp_count = 0, first = last = 0.
  - EARLY_EXIT = 1, code = 25: response 1 cycle after acceptance (f(0) = 20 < 25).
  - EARLY_EXIT = 1, code = 5: full 16 cycles.
- Hold rsp_ready = 0 for 10 cycles with req_valid high and a new code -> outputs stable, req_ready = 0. Release -> handshake, then the second request is accepted and answered correctly.
- Assert rst_n low at SCAN cycle 8 of req_code = 18 -> all outputs at reset values immediately, no rsp_valid. A new request for code 18 after release -> count = 2, first = 3, last = 4.
- Exhaustive sweep of codes 0..31, back-to-back with rsp_ready = 1 -> every response matches the inverse computed from logic_table_lookup.
